// File: rtl/dutmem_arb_pkg.sv
// Shared types and width helpers for the dutMem round-robin arbiter.
package dutmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter able to hold the value t; never narrower than one bit.
  function automatic int cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/dutmem_rr_pick.sv
// Combinational round-robin picker: lowest requester strictly after ptr wins,
// wrapping from NUM_REQ-1 back to 0.
module dutmem_rr_pick
  import dutmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [idx_w(NUM_REQ)-1:0]   ptr,
  output logic [NUM_REQ-1:0]          grant,
  output logic [idx_w(NUM_REQ)-1:0]   grant_idx,
  output logic                        valid
);

  localparam int IW  = idx_w(NUM_REQ);
  localparam int DW2 = 2 * NUM_REQ;
  localparam int PW  = $clog2(DW2);

  logic [DW2-1:0] dbl_s;
  logic [DW2-1:0] mask_s;
  logic [DW2-1:0] masked_s;
  logic [PW-1:0]  pos_s;

  // Doubling the vector turns the wrap-around search into a plain lowest-bit search.
  assign dbl_s    = {req, req};
  assign mask_s   = {DW2{1'b1}} << (32'(ptr) + 32'd1);
  assign masked_s = dbl_s & mask_s;
  assign valid    = |req;

  // Lowest set bit of the masked doubled vector.
  always_comb begin
    pos_s = '0;
    for (int i = DW2 - 1; i >= 0; i--) begin
      pos_s = masked_s[i] ? PW'(i) : pos_s;
    end
  end

  // Fold the doubled position back into a requester index and one-hot grant.
  always_comb begin
    grant_idx = '0;
    grant     = '0;
    if (pos_s >= PW'(NUM_REQ)) begin
      grant_idx = IW'(pos_s - PW'(NUM_REQ));
    end else begin
      grant_idx = IW'(pos_s);
    end
    if (valid) begin
      grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/dutmem_arbiter.sv
// Round-robin sequencer sharing one dutMem port among NUM_REQ requesters,
// with a watchdog that aborts transactions whose mem_ready never arrives.
module dutmem_arbiter
  import dutmem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [idx_w(NUM_REQ)-1:0]      grant_id,
  output logic                           busy,
  output logic                           mem_sel,
  output logic                           mem_wr_rd,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  input  logic                           mem_ready
);

  localparam int               IW     = idx_w(NUM_REQ);
  localparam int               CW     = cnt_w(TIMEOUT);
  localparam bit               WD_EN  = (TIMEOUT != 0);
  localparam logic [CW-1:0]    TO_CNT = CW'(TIMEOUT);

  arb_state_e              state_r;
  arb_state_e              state_s;
  logic [IW-1:0]           last_grant_r;
  logic [IW-1:0]           grant_id_r;
  logic [NUM_REQ-1:0]      ack_mask_r;
  logic [NUM_REQ-1:0]      req_ack_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    rsp_err_r;
  logic                    busy_r;
  logic                    mem_sel_r;
  logic                    mem_wr_rd_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic [CW-1:0]           wd_r;

  logic [NUM_REQ-1:0]      pick_grant_s;
  logic [IW-1:0]           pick_idx_s;
  logic                    pick_valid_s;
  logic                    done_ok_s;
  logic                    done_to_s;

  dutmem_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req       (req_valid),
    .ptr       (last_grant_r),
    .grant     (pick_grant_s),
    .grant_idx (pick_idx_s),
    .valid     (pick_valid_s)
  );

  // Next-state logic and completion qualifiers.
  always_comb begin
    state_s   = state_r;
    done_ok_s = 1'b0;
    done_to_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          state_s   = ST_DONE;
          done_ok_s = 1'b1;
        end else if (WD_EN && (wd_r == TO_CNT)) begin
          state_s   = ST_DONE;
          done_to_s = 1'b1;
        end else begin
          state_s   = ST_BUSY;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, transaction latches, watchdog and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IW'(NUM_REQ - 1);
      grant_id_r   <= '0;
      ack_mask_r   <= '0;
      req_ack_r    <= '0;
      rsp_rdata_r  <= '0;
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
      mem_sel_r    <= 1'b0;
      mem_wr_rd_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      wd_r         <= '0;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s != ST_IDLE);
      mem_sel_r <= (state_s == ST_BUSY);
      req_ack_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_id_r   <= pick_idx_s;
            last_grant_r <= pick_idx_s;
            ack_mask_r   <= pick_grant_s;
            mem_wr_rd_r  <= req_wr_rd[pick_idx_s];
            mem_addr_r   <= req_addr[pick_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_r  <= req_wdata[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
            wd_r         <= '0;
          end
        end
        ST_BUSY: begin
          if (done_ok_s) begin
            rsp_rdata_r <= mem_wr_rd_r ? '0 : mem_rdata;
            rsp_err_r   <= 1'b0;
            req_ack_r   <= ack_mask_r;
          end else if (done_to_s) begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b1;
            req_ack_r   <= ack_mask_r;
          end else begin
            wd_r <= wd_r + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ack   = req_ack_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign grant_id  = grant_id_r;
  assign busy      = busy_r;
  assign mem_sel   = mem_sel_r;
  assign mem_wr_rd = mem_wr_rd_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dutmem_arbiter.sv
// Directed self-checking bench for dutmem_arbiter (4 requesters, TIMEOUT=4).
module tb_dutmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_wr_rd;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_ack;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  grant_id;
  logic        busy;
  logic        mem_sel;
  logic        mem_wr_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_pass   = 0;

  dutmem_arbiter #(
    .NUM_REQ    (4),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (16),
    .TIMEOUT    (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_wr_rd (req_wr_rd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .grant_id  (grant_id),
    .busy      (busy),
    .mem_sel   (mem_sel),
    .mem_wr_rd (mem_wr_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction from the current request setup; mem_ready rises after
  // 'waits' wait states. Optionally disturbs requester 2's address while busy.
  task automatic run_txn(input int waits, input logic [7:0] exp_addr, input logic exp_wr,
                         input logic [15:0] exp_wd, input logic perturb,
                         output int sel_cyc, output logic [3:0] ack,
                         output logic [15:0] rdata, output logic err, output int bad);
    sel_cyc = 0;
    bad     = 0;
    ack     = 4'b0000;
    rdata   = 16'h0000;
    err     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) begin
        ack       = req_ack;
        rdata     = rsp_rdata;
        err       = rsp_err;
        mem_ready = 1'b0;
        break;
      end
      if (mem_sel) begin
        sel_cyc++;
        if (mem_addr !== exp_addr || mem_wr_rd !== exp_wr || mem_wdata !== exp_wd) bad++;
        if (perturb) req_addr[23:16] = 8'(sel_cyc * 37);
        mem_ready = (sel_cyc == waits + 1);
      end
    end
  endtask

  int          sc;
  int          bd;
  logic [3:0]  ak;
  logic [15:0] rd;
  logic        er;
  int          ids [5];
  int          acyc [5];
  int          nack;

  initial begin
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_wr_rd = 4'b0000;
    req_addr  = 32'h0;
    req_wdata = 64'h0;
    mem_rdata = 16'h0000;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    check_eq("rst_mem_sel", 32'(mem_sel), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ack", 32'(req_ack), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Round robin: everyone requesting, memory always ready (also stray in IDLE/DONE).
    req_addr  = 32'h33_22_11_00;
    req_valid = 4'b1111;
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ids[k]  = -1;
      acyc[k] = 0;
    end
    nack = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) begin
        for (int b = 0; b < 4; b++) begin
          if (req_ack[b]) ids[nack] = b;
        end
        acyc[nack] = c;
        nack++;
        if (nack == 5) begin
          req_valid = 4'b0000;
          mem_ready = 1'b0;
          break;
        end
      end
    end
    check_eq("rr_ack_count", 32'(nack), 32'd5);
    check_eq("rr_id0", 32'(ids[0]), 32'd0);
    check_eq("rr_id1", 32'(ids[1]), 32'd1);
    check_eq("rr_id2", 32'(ids[2]), 32'd2);
    check_eq("rr_id3", 32'(ids[3]), 32'd3);
    check_eq("rr_id4", 32'(ids[4]), 32'd0);
    for (int k = 1; k < 5; k++) begin
      check_eq("rr_spacing", 32'(acyc[k] - acyc[k-1]), 32'd3);
    end
    @(negedge clk);

    // Single read from requester 2, two wait states.
    req_addr[23:16] = 8'h3C;
    req_valid       = 4'b0100;
    mem_rdata       = 16'hBEEF;
    run_txn(2, 8'h3C, 1'b0, 16'h0000, 1'b0, sc, ak, rd, er, bd);
    req_valid = 4'b0000;
    check_eq("rd_sel_cycles", 32'(sc), 32'd3);
    check_eq("rd_ack", 32'(ak), 32'h4);
    check_eq("rd_rdata", 32'(rd), 32'hBEEF);
    check_eq("rd_err", 32'(er), 32'd0);
    check_eq("rd_stable", 32'(bd), 32'd0);
    check_eq("rd_grant_id", 32'(grant_id), 32'd2);
    @(negedge clk);
    check_eq("rd_ack_one_cycle", 32'(req_ack), 32'd0);
    check_eq("rd_rdata_held", 32'(rsp_rdata), 32'hBEEF);
    check_eq("rd_busy_idle", 32'(busy), 32'd0);

    // Write from requester 1, one wait state.
    req_addr[15:8]    = 8'h80;
    req_wdata[31:16]  = 16'h1234;
    req_wr_rd         = 4'b0010;
    req_valid         = 4'b0010;
    run_txn(1, 8'h80, 1'b1, 16'h1234, 1'b0, sc, ak, rd, er, bd);
    req_valid = 4'b0000;
    req_wr_rd = 4'b0000;
    req_wdata = 64'h0;
    check_eq("wr_sel_cycles", 32'(sc), 32'd2);
    check_eq("wr_ack", 32'(ak), 32'h2);
    check_eq("wr_rdata_zero", 32'(rd), 32'd0);
    check_eq("wr_stable", 32'(bd), 32'd0);
    @(negedge clk);

    // Timeout on requester 2 with requester 3 pending behind it.
    req_addr[23:16] = 8'h5C;
    req_addr[31:24] = 8'h7E;
    req_valid       = 4'b1100;
    run_txn(100, 8'h5C, 1'b0, 16'h0000, 1'b0, sc, ak, rd, er, bd);
    req_valid = 4'b1000;
    check_eq("to_sel_cycles", 32'(sc), 32'd5);
    check_eq("to_ack", 32'(ak), 32'h4);
    check_eq("to_err", 32'(er), 32'd1);
    check_eq("to_rdata", 32'(rd), 32'd0);
    mem_rdata = 16'h5A5A;
    run_txn(0, 8'h7E, 1'b0, 16'h0000, 1'b0, sc, ak, rd, er, bd);
    req_valid = 4'b0000;
    check_eq("after_to_ack", 32'(ak), 32'h8);
    check_eq("after_to_err", 32'(er), 32'd0);
    check_eq("after_to_rdata", 32'(rd), 32'h5A5A);
    @(negedge clk);

    // Stability: requester 0 granted while requester 2 keeps changing its address.
    req_addr[7:0]   = 8'h40;
    req_valid       = 4'b0101;
    run_txn(2, 8'h40, 1'b0, 16'h0000, 1'b1, sc, ak, rd, er, bd);
    req_valid = 4'b0000;
    check_eq("stab_ack", 32'(ak), 32'h1);
    check_eq("stab_addr_held", 32'(bd), 32'd0);
    check_eq("stab_sel_cycles", 32'(sc), 32'd3);
    @(negedge clk);

    // Reset two cycles into a transaction for requester 1.
    req_addr[15:8] = 8'h11;
    req_valid      = 4'b0010;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_sel", 32'(mem_sel), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_sel", 32'(mem_sel), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
    check_eq("mid_rst_grant", 32'(grant_id), 32'd0);
    req_valid = 4'b1001;
    @(negedge clk);
    check_eq("mid_rst_no_ack", 32'(req_ack), 32'd0);
    reset_n = 1'b1;
    run_txn(0, 8'h40, 1'b0, 16'h0000, 1'b0, sc, ak, rd, er, bd);
    req_valid = 4'b0000;
    check_eq("post_rst_ack", 32'(ak), 32'h1);
    check_eq("post_rst_grant", 32'(grant_id), 32'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dutmem_arbiter.md
# dutmem_arbiter

Round-robin arbiter and transaction sequencer that shares one dutMem memory port among NUM_REQ requesters. Each requester posts a single read or write. The block latches the winner, drives the memory select/address/data until the memory returns ready, then returns read data and a one-cycle acknowledge to the winner. A watchdog aborts any transaction whose ready never arrives, so a hung memory cannot deadlock the other requesters.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_WIDTH, 8: memory address width
- DATA_WIDTH, 16: memory data width
- TIMEOUT, 255: maximum cycles waiting for mem_ready; 0 disables the watchdog

Ports:
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request; held until its req_ack
- req_wr_rd  in  NUM_REQ  per-requester direction; 1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data; requester i in slice i
- req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; valid while req_ack is high
- rsp_err  out  1  timeout flag; valid while req_ack is high
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
- busy  out  1  high outside IDLE
- mem_sel  out  1  memory select
- mem_wr_rd  out  1  memory direction
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_ready  in  1  memory completion

## Operation
- **FSM states:** IDLE, BUSY, DONE. All outputs are registered.
- **IDLE:**
  - If any req_valid bit is high, pick a winner by round robin. Search starts at last_grant+1 and wraps at NUM_REQ-1 to 0.
  - Latch the winner's wr_rd, addr and wdata; set grant_id; load last_grant; clear the watchdog; go to BUSY.
- **BUSY:**
  - mem_sel=1. mem_wr_rd, mem_addr and mem_wdata hold the latched values, stable for the whole state.
  - mem_ready sampled high: capture mem_rdata for a read (0 for a write), rsp_err=0, go to DONE.
  - Otherwise the watchdog increments. If TIMEOUT≠0 and the count reaches TIMEOUT: rsp_err=1, rsp_rdata=0, go to DONE.
- **DONE:**
  - mem_sel=0; req_ack[grant_id]=1 for exactly this cycle. No arbitration happens here.
  - Next state is IDLE. This gives the requester one edge to drop or replace req_valid.
- **Request inputs:** ignored except in IDLE. Changes to non-granted requests never affect the transaction in flight.
- **Simultaneous requests:** the highest priority relative to the pointer wins; the others wait. With all requesters busy, service is strictly 0,1,2,…,NUM_REQ-1,0.
- **Sole requester:** re-granted each round with no starvation penalty.
- **Latched mem_rdata:** rsp_rdata and rsp_err hold their values until the next DONE.

## Timing
- **Reset values:**
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 wins first after reset.
  - mem_sel, mem_wr_rd, mem_addr, mem_wdata = 0.
  - req_ack, rsp_rdata, rsp_err, grant_id, busy = 0.
- **Zero-wait memory:**
  - req_valid is seen at edge E0; mem_sel rises after E0.
  - mem_ready is sampled at E1; req_ack is high from E1 to E2.
  - The next grant is at E2, with mem_sel high again after E2.
  - Minimum 3 cycles per transaction; mem_sel is low for at least one cycle between transactions.
- **Each wait state** adds one cycle.
- **Timeout:** req_ack with rsp_err=1 is asserted TIMEOUT+1 cycles after mem_sel rises.
- **Stray mem_ready:** mem_ready in IDLE or DONE is ignored.
- **reset_n low mid-transaction:** immediate return to reset values and no ack for the aborted request. The requester must re-issue.

## Structure
- **Package dutmem_arb_pkg:** state enum (IDLE/BUSY/DONE) and a width helper for the grant index. ADDR_WIDTH and DATA_WIDTH stay module parameters.
- **Sub-module dutmem_rr_pick:** combinational. Inputs are the request vector and pointer; outputs are a one-hot grant plus its index. Use a double-width masked priority search.
- **Top level:** FSM, latches and watchdog counter, width $clog2(TIMEOUT+1).

## Test plan
- Single read: req_valid[2]=1, addr=0x3C; memory returns 0xBEEF after 2 wait states → mem_sel high for 3 cycles with addr 0x3C and wr_rd 0. Then req_ack=4'b0100 and rsp_rdata=0xBEEF for 1 cycle, rsp_err=0.
- Round robin: all four req_valid held high, zero-wait memory → grant order 0,1,2,3,0. Each req_ack is exactly 3 cycles apart.
- Write: req 1 writes 0x1234 to 0x80 → mem_wr_rd=1, mem_wdata=0x1234 stable during BUSY. req_ack[1] pulses with rsp_rdata=0.
- Timeout: TIMEOUT=4, mem_ready stuck low → req_ack after 5 mem_sel cycles with rsp_err=1. The next pending requester is then granted normally.
- Reset mid-BUSY: reset_n pulled low two cycles into a transaction → all outputs 0 immediately, with no ack. After release with req 3 and req 0 both pending, req 0 wins.
- Stability: a non-granted requester changes addr during BUSY → mem_addr unchanged, and the ack goes only to the granted requester.
